// File: rtl/axi_sram_if.sv
// AXI3 bus bundle between a master (cache layer / crossbar) and the SRAM responder.
// Carries AW/W/B/AR/R channels; the master drives requests, the slave drives ready and responses.
interface axi_sram_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [3:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;

  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [3:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;

  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    output rready,
    input  awready, wready, bid, bresp, bvalid,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    input  rready,
    output awready, wready, bid, bresp, bvalid,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_sram_responder.sv
// AXI3 slave backed by an on-chip word array; independent read and write engines,
// one outstanding burst per direction, INCR/WRAP/FIXED bursts of 1-16 beats.
module axi_sram_responder #(
  parameter int MEM_ADDR_BITS = 16,
  parameter int READ_LATENCY  = 2,
  parameter int ID_W          = 4
) (
  input  logic      clk,
  input  logic      reset,
  axi_sram_if.slave axi
);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BEAT} rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [7:0] LAT_INIT    = 8'(READ_LATENCY - 1);

  logic [31:0] mem [0:(2**MEM_ADDR_BITS)-1];

  function automatic logic [31:0] beatStep(input logic [2:0] size);
    return (size > 3'd2) ? 32'd4 : (32'd1 << size);
  endfunction

  function automatic logic wrapLenOk(input logic [3:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

  function automatic logic burstErr(input logic [1:0] burst, input logic [3:0] len,
                                    input logic [2:0] size);
    return (size > 3'd2) || (burst == 2'b11) || ((burst == BURST_WRAP) && !wrapLenOk(len));
  endfunction

  // Reserved burst codes and malformed wraps fall back to INCR stepping
  function automatic logic [1:0] effBurst(input logic [1:0] burst, input logic [3:0] len);
    if (burst == 2'b11) return BURST_INCR;
    if ((burst == BURST_WRAP) && !wrapLenOk(len)) return BURST_INCR;
    return burst;
  endfunction

  function automatic logic [31:0] nextAddr(input logic [31:0] addr, input logic [1:0] burst,
                                           input logic [3:0] len, input logic [2:0] size);
    logic [31:0] step;
    logic [31:0] bnd;
    step = beatStep(size);
    bnd  = ({28'd0, len} + 32'd1) * step;
    case (burst)
      BURST_FIXED: return addr;
      BURST_WRAP:  return (addr & ~(bnd - 32'd1)) | ((addr + step) & (bnd - 32'd1));
      default:     return addr + step;
    endcase
  endfunction

  rstate_e             rState_q;
  logic [31:0]         rAddr_q;
  logic [31:0]         rAddr_d;
  logic [3:0]          rLen_q;
  logic [2:0]          rSize_q;
  logic [1:0]          rBurst_q;
  logic [3:0]          rBeatCnt_q;
  logic [7:0]          rLatCnt_q;
  logic                arReady_q;
  logic                rValid_q;
  logic                rLast_q;
  logic [ID_W-1:0]     rId_q;
  logic [31:0]         rData_q;
  logic [1:0]          rResp_q;

  wstate_e             wState_q;
  logic [31:0]         wAddr_q;
  logic [31:0]         wAddr_d;
  logic [3:0]          wLen_q;
  logic [2:0]          wSize_q;
  logic [1:0]          wBurst_q;
  logic [3:0]          wBeatCnt_q;
  logic                wErr_q;
  logic                awReady_q;
  logic                wReady_q;
  logic                bValid_q;
  logic [ID_W-1:0]     bId_q;
  logic [1:0]          bResp_q;

  logic                wFire;
  logic                wLastBad;

  assign rAddr_d  = nextAddr(rAddr_q, rBurst_q, rLen_q, rSize_q);
  assign wAddr_d  = nextAddr(wAddr_q, wBurst_q, wLen_q, wSize_q);
  assign wFire    = (wState_q == W_DATA) && axi.wvalid && wReady_q;
  assign wLastBad = axi.wlast != (wBeatCnt_q == 4'd0);

  assign axi.arready = arReady_q;
  assign axi.rvalid  = rValid_q;
  assign axi.rlast   = rLast_q;
  assign axi.rid     = rId_q;
  assign axi.rdata   = rData_q;
  assign axi.rresp   = rResp_q;
  assign axi.awready = awReady_q;
  assign axi.wready  = wReady_q;
  assign axi.bvalid  = bValid_q;
  assign axi.bid     = bId_q;
  assign axi.bresp   = bResp_q;

  // Read engine: reading the array inside the same edge as a write returns the old word
  always_ff @(posedge clk) begin
    if (reset) begin
      rState_q   <= R_IDLE;
      rAddr_q    <= '0;
      rLen_q     <= '0;
      rSize_q    <= '0;
      rBurst_q   <= '0;
      rBeatCnt_q <= '0;
      rLatCnt_q  <= '0;
      arReady_q  <= 1'b0;
      rValid_q   <= 1'b0;
      rLast_q    <= 1'b0;
      rId_q      <= '0;
      rData_q    <= '0;
      rResp_q    <= RESP_OKAY;
    end else begin
      case (rState_q)
        R_IDLE: begin
          arReady_q <= 1'b1;
          if (axi.arvalid && arReady_q) begin
            arReady_q  <= 1'b0;
            rAddr_q    <= axi.araddr;
            rLen_q     <= axi.arlen;
            rSize_q    <= axi.arsize;
            rBurst_q   <= effBurst(axi.arburst, axi.arlen);
            rBeatCnt_q <= axi.arlen;
            rLatCnt_q  <= LAT_INIT;
            rId_q      <= axi.arid;
            rResp_q    <= burstErr(axi.arburst, axi.arlen, axi.arsize) ? RESP_SLVERR : RESP_OKAY;
            rState_q   <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (rLatCnt_q == 8'd0) begin
            rValid_q <= 1'b1;
            rData_q  <= mem[rAddr_q[MEM_ADDR_BITS+1:2]];
            rLast_q  <= (rBeatCnt_q == 4'd0);
            rState_q <= R_BEAT;
          end else begin
            rLatCnt_q <= rLatCnt_q - 8'd1;
          end
        end
        R_BEAT: begin
          if (axi.rready) begin
            if (rBeatCnt_q == 4'd0) begin
              rValid_q  <= 1'b0;
              rLast_q   <= 1'b0;
              arReady_q <= 1'b1;
              rState_q  <= R_IDLE;
            end else begin
              rAddr_q    <= rAddr_d;
              rBeatCnt_q <= rBeatCnt_q - 4'd1;
              rData_q    <= mem[rAddr_d[MEM_ADDR_BITS+1:2]];
              rLast_q    <= (rBeatCnt_q == 4'd1);
            end
          end
        end
        default: rState_q <= R_IDLE;
      endcase
    end
  end

  // Write engine: awlen alone decides the burst length, a misplaced wlast only flags SLVERR
  always_ff @(posedge clk) begin
    if (reset) begin
      wState_q   <= W_IDLE;
      wAddr_q    <= '0;
      wLen_q     <= '0;
      wSize_q    <= '0;
      wBurst_q   <= '0;
      wBeatCnt_q <= '0;
      wErr_q     <= 1'b0;
      awReady_q  <= 1'b0;
      wReady_q   <= 1'b0;
      bValid_q   <= 1'b0;
      bId_q      <= '0;
      bResp_q    <= RESP_OKAY;
    end else begin
      case (wState_q)
        W_IDLE: begin
          awReady_q <= 1'b1;
          if (axi.awvalid && awReady_q) begin
            awReady_q  <= 1'b0;
            wReady_q   <= 1'b1;
            wAddr_q    <= axi.awaddr;
            wLen_q     <= axi.awlen;
            wSize_q    <= axi.awsize;
            wBurst_q   <= effBurst(axi.awburst, axi.awlen);
            wBeatCnt_q <= axi.awlen;
            wErr_q     <= burstErr(axi.awburst, axi.awlen, axi.awsize);
            bId_q      <= axi.awid;
            wState_q   <= W_DATA;
          end
        end
        W_DATA: begin
          if (wFire) begin
            wAddr_q <= wAddr_d;
            if (wBeatCnt_q == 4'd0) begin
              wReady_q <= 1'b0;
              bValid_q <= 1'b1;
              bResp_q  <= (wErr_q || wLastBad) ? RESP_SLVERR : RESP_OKAY;
              wState_q <= W_RESP;
            end else begin
              wBeatCnt_q <= wBeatCnt_q - 4'd1;
              wErr_q     <= wErr_q || wLastBad;
            end
          end
        end
        W_RESP: begin
          if (axi.bready) begin
            bValid_q  <= 1'b0;
            awReady_q <= 1'b1;
            wState_q  <= W_IDLE;
          end
        end
        default: wState_q <= W_IDLE;
      endcase
    end
  end

  // Array contents are deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (!reset && wFire) begin
      for (int b = 0; b < 4; b++) begin
        if (axi.wstrb[b]) begin
          mem[wAddr_q[MEM_ADDR_BITS+1:2]][8*b +: 8] <= axi.wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_responder.sv
// Randomised self-checking bench for axi_sram_responder against a byte-level memory
// model and burst address rules computed with plain arithmetic.
module tb_axi_sram_responder;

  localparam int MAB = 16;
  localparam int RL  = 2;
  localparam int IDW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  axi_sram_if #(.ID_W(IDW)) axi ();

  axi_sram_responder #(
    .MEM_ADDR_BITS(MAB),
    .READ_LATENCY (RL),
    .ID_W         (IDW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .axi  (axi)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] modelMem [int];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int wordIdx(input logic [31:0] a);
    return int'((a >> 2) % (32'd1 << MAB));
  endfunction

  function automatic logic [31:0] beatAddr(input logic [31:0] start, input logic [3:0] len,
                                           input logic [2:0] size, input logic [1:0] burst,
                                           input int i);
    logic [31:0] step;
    logic [31:0] bnd;
    logic [31:0] lower;
    step = (size > 3'd2) ? 32'd4 : (32'd1 << size);
    if (burst == 2'b00) return start;
    if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      bnd   = (32'(len) + 32'd1) * step;
      lower = (start / bnd) * bnd;
      return lower + ((start - lower + 32'(i) * step) % bnd);
    end
    return start + 32'(i) * step;
  endfunction

  function automatic logic [1:0] expResp(input logic [3:0] len, input logic [2:0] size,
                                         input logic [1:0] burst);
    bit err;
    err = (size > 3'd2) || (burst == 2'b11) ||
          (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
    return err ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    int k;
    k = wordIdx(a);
    return modelMem.exists(k) ? modelMem[k] : 32'hxxxx_xxxx;
  endfunction

  task automatic modelWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    w = modelRead(a);
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    modelMem[wordIdx(a)] = w;
  endtask

  task automatic doWrite(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input logic [31:0] data [16], input logic [3:0] strb [16],
                         input int lastBeat, input string tag);
    int n;
    logic [1:0] er;
    axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awsize = size; axi.awburst = burst;
    axi.awvalid = 1'b1;
    n = 0;
    while (!axi.awready && n < 200) begin @(negedge clk); n++; end
    if (!axi.awready) begin
      checkOutput({tag, " awready"}, axi.awready, 1'b1);
      axi.awvalid = 1'b0;
      return;
    end
    @(negedge clk);
    axi.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      axi.wdata = data[i]; axi.wstrb = strb[i]; axi.wlast = (i == lastBeat); axi.wvalid = 1'b1;
      n = 0;
      while (!axi.wready && n < 200) begin @(negedge clk); n++; end
      if (!axi.wready) begin
        checkOutput({tag, " wready"}, axi.wready, 1'b1);
        axi.wvalid = 1'b0;
        return;
      end
      @(negedge clk);
      modelWrite(beatAddr(addr, len, size, burst, i), data[i], strb[i]);
    end
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
    axi.bready = 1'b1;
    n = 0;
    while (!axi.bvalid && n < 200) begin @(negedge clk); n++; end
    er = (lastBeat != int'(len)) ? 2'b10 : expResp(len, size, burst);
    checkOutput({tag, " bvalid"}, axi.bvalid, 1'b1);
    checkOutput({tag, " bresp"}, axi.bresp, er);
    checkOutput({tag, " bid"}, axi.bid, id);
    @(negedge clk);
    axi.bready = 1'b0;
  endtask

  task automatic arIssue(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input string tag,
                         output bit ok);
    int n;
    axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arsize = size; axi.arburst = burst;
    axi.arvalid = 1'b1;
    n = 0;
    while (!axi.arready && n < 200) begin @(negedge clk); n++; end
    ok = axi.arready;
    if (!ok) checkOutput({tag, " arready"}, axi.arready, 1'b1);
    @(negedge clk);
    axi.arvalid = 1'b0;
  endtask

  function automatic int pickStall(input int beat, input int stallBeat, input bit rs);
    if (beat == stallBeat) return 3;
    if (rs) return int'($urandom_range(0, 2));
    return 0;
  endfunction

  task automatic doRead(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [3:0] len,
                        input logic [2:0] size, input logic [1:0] burst, input bit checkLat,
                        input int stallBeat, input bit randStall, input string tag);
    bit ok;
    int edges;
    int i;
    int guard;
    int stallLeft;
    arIssue(id, addr, len, size, burst, tag, ok);
    if (!ok) return;
    edges = 0;
    while (!axi.rvalid && edges < 200) begin @(negedge clk); edges++; end
    if (checkLat) checkOutput({tag, " latency"}, edges, RL);
    i = 0; guard = 0;
    stallLeft = pickStall(0, stallBeat, randStall);
    while (i <= int'(len) && guard < 500) begin
      if (axi.rvalid) begin
        checkOutput({tag, " rdata"}, axi.rdata, modelRead(beatAddr(addr, len, size, burst, i)));
        checkOutput({tag, " rid"}, axi.rid, id);
        checkOutput({tag, " rresp"}, axi.rresp, expResp(len, size, burst));
        checkOutput({tag, " rlast"}, axi.rlast, (i == int'(len)));
        if (stallLeft > 0) begin
          axi.rready = 1'b0;
          stallLeft--;
        end else begin
          axi.rready = 1'b1;
          i++;
          stallLeft = pickStall(i, stallBeat, randStall);
        end
      end else begin
        axi.rready = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    axi.rready = 1'b0;
    if (i <= int'(len)) begin
      checkOutput({tag, " beats"}, i, int'(len) + 1);
    end else begin
      checkOutput({tag, " rvalid after last"}, axi.rvalid, 1'b0);
      checkOutput({tag, " arready after last"}, axi.arready, 1'b1);
    end
  endtask

  task automatic applyStimulus(input int numOps);
    logic [31:0] d [16];
    logic [3:0]  s [16];
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [31:0] addr;
    int lb;
    for (int blk = 0; blk < 16; blk++) begin
      for (int k = 0; k < 16; k++) begin d[k] = $urandom; s[k] = 4'hF; end
      doWrite(4'(blk), 32'(blk * 64), 4'd15, 3'd2, 2'b01, d, s, 15, "prefill");
    end
    for (int op = 0; op < numOps; op++) begin
      len   = 4'($urandom_range(0, 15));
      size  = 3'($urandom_range(0, 3));
      burst = 2'($urandom_range(0, 3));
      addr  = 32'($urandom_range(0, 32'h2FF)) & ~32'd3;
      if ($urandom_range(0, 2) == 0) len = 4'd3;
      if ($urandom_range(0, 1) == 0) begin
        for (int k = 0; k < 16; k++) begin d[k] = $urandom; s[k] = 4'($urandom_range(0, 15)); end
        lb = int'(len);
        if ($urandom_range(0, 4) == 0) lb = int'($urandom_range(0, int'(len) + 1));
        doWrite(4'($urandom_range(0, 15)), addr, len, size, burst, d, s, lb, "rand wr");
      end else begin
        doRead(4'($urandom_range(0, 15)), addr, len, size, burst, 1'b0, -1, 1'b1, "rand rd");
      end
    end
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] d [16];
    logic [3:0]  s [16];
    bit ok;
    int n;
    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
    axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b0;
    axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0;
    axi.arvalid = 1'b0; axi.rready = 1'b0;
    for (int k = 0; k < 16; k++) begin d[k] = '0; s[k] = 4'hF; end

    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset arready", axi.arready, 1'b0);
    checkOutput("reset awready", axi.awready, 1'b0);
    checkOutput("reset wready", axi.wready, 1'b0);
    checkOutput("reset rvalid", axi.rvalid, 1'b0);
    checkOutput("reset bvalid", axi.bvalid, 1'b0);
    checkOutput("reset rlast", axi.rlast, 1'b0);
    checkOutput("reset rid/bid", {axi.rid, axi.bid}, '0);
    checkOutput("reset rdata", axi.rdata, 32'h0);
    checkOutput("reset resp", {axi.rresp, axi.bresp}, 4'h0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post-reset arready", axi.arready, 1'b1);
    checkOutput("post-reset awready", axi.awready, 1'b1);

    // W data offered before any AW must be held off
    axi.wdata = 32'hBAD0BAD0; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    repeat (3) begin
      checkOutput("early wready", axi.wready, 1'b0);
      @(negedge clk);
    end
    axi.wvalid = 1'b0;

    d[0] = 32'hDEADBEEF;
    doWrite(4'd3, 32'h1000, 4'd0, 3'd2, 2'b01, d, s, 0, "t1 wr");
    doRead(4'd5, 32'h1000, 4'd0, 3'd2, 2'b01, 1'b1, -1, 1'b0, "t1 rd");

    for (int k = 0; k < 4; k++) d[k] = 32'(k + 1);
    doWrite(4'd1, 32'h2000, 4'd3, 3'd2, 2'b01, d, s, 3, "t2 wr");
    doRead(4'd2, 32'h2000, 4'd3, 3'd2, 2'b01, 1'b1, 1, 1'b0, "t2 rd");

    d[0] = 32'h0000000A; d[1] = 32'h0000000B; d[2] = 32'h0000000C; d[3] = 32'h0000000D;
    doWrite(4'd4, 32'h2000, 4'd3, 3'd2, 2'b01, d, s, 3, "t3 wr");
    doRead(4'd6, 32'h200C, 4'd3, 3'd2, 2'b10, 1'b0, -1, 1'b0, "t3 wrap rd");

    d[0] = 32'h11223344;
    doWrite(4'd7, 32'h3000, 4'd0, 3'd2, 2'b01, d, s, 0, "t4 wr full");
    d[0] = 32'hAAAAAAAA; s[0] = 4'h2;
    doWrite(4'd7, 32'h3000, 4'd0, 3'd2, 2'b01, d, s, 0, "t4 wr strb");
    s[0] = 4'hF;
    doRead(4'd8, 32'h3000, 4'd0, 3'd2, 2'b01, 1'b0, -1, 1'b0, "t4 rd");

    // Early wlast with a read burst and simultaneous AR/AW handshakes
    for (int k = 0; k < 4; k++) d[k] = 32'h5A5A0000 + 32'(k);
    fork
      doWrite(4'd9, 32'h4000, 4'd3, 3'd2, 2'b01, d, s, 1, "t5 wr");
      doRead(4'd10, 32'h2000, 4'd3, 3'd2, 2'b01, 1'b0, -1, 1'b1, "t5 rd");
    join
    doRead(4'd11, 32'h4000, 4'd3, 3'd2, 2'b01, 1'b0, -1, 1'b0, "t5 rd back");

    arIssue(4'd12, 32'h2000, 4'd3, 3'd2, 2'b01, "t6 ar", ok);
    n = 0;
    while (!axi.rvalid && n < 200) begin @(negedge clk); n++; end
    axi.rready = 1'b1;
    @(negedge clk);
    axi.rready = 1'b0;
    checkOutput("t6 beat2 rvalid", axi.rvalid, 1'b1);
    checkOutput("t6 beat2 rdata", axi.rdata, modelRead(32'h2004));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("t6 rvalid after reset", axi.rvalid, 1'b0);
    checkOutput("t6 rlast after reset", axi.rlast, 1'b0);
    @(negedge clk);
    checkOutput("t6 arready after reset", axi.arready, 1'b1);
    checkOutput("t6 rvalid stays low", axi.rvalid, 1'b0);
    doRead(4'd13, 32'h2008, 4'd0, 3'd2, 2'b01, 1'b1, -1, 1'b0, "t6 rd");

    d[0] = 32'hCAFEF00D;
    doWrite(4'd14, 32'h0004_0010, 4'd0, 3'd2, 2'b01, d, s, 0, "alias wr");
    doRead(4'd15, 32'h0000_0010, 4'd0, 3'd2, 2'b01, 1'b0, -1, 1'b0, "alias rd");

    for (int k = 0; k < 3; k++) begin d[k] = $urandom; s[k] = 4'(1 << k); end
    doWrite(4'd2, 32'h5000, 4'd2, 3'd2, 2'b00, d, s, 2, "fixed wr");
    doRead(4'd3, 32'h5000, 4'd2, 3'd2, 2'b00, 1'b0, -1, 1'b0, "fixed rd");

    applyStimulus(80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
